// File: rtl/dbg_trace_pkg.sv
// Shared state encoding for the debug trace capture block.
package dbg_trace_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ARMED = 2'd1;
    localparam logic [1:0] STATE_POST  = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        ARMED = STATE_ARMED,
        POST  = STATE_POST,
        DONE  = STATE_DONE
    } state_e;

endpackage

// File: rtl/dbg_trace_ram.sv
// Trace storage: one write port, one registered read port, read-before-write, no reset.
// Latency 1 cycle on read; no backpressure.
module dbg_trace_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dbg_trace_capture.sv
// Live probe mux plus triggered circular trace of one channel, read back oldest-first.
// Latency 1 cycle on live and read data; no backpressure, capture runs every cycle.
module dbg_trace_capture
    import dbg_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 16,
    parameter int DEPTH  = 64,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
    input  logic [SEL_W-1:0]         i_select,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic                     i_trig,
    input  logic [ADDR_W-1:0]        i_post_cnt,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic [DATA_W-1:0]        o_live_data,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [1:0]               o_state,
    output logic                     o_done,
    output logic [ADDR_W:0]          o_valid_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    state_e            state;
    logic [SEL_W-1:0]  cap_sel;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_rem;
    logic [CNT_W-1:0]  valid_cnt;
    logic              wrapped;
    logic              rd_ok;
    logic [DATA_W-1:0] live_mux;
    logic [DATA_W-1:0] cap_mux;
    logic [DATA_W-1:0] ram_q;
    logic [ADDR_W-1:0] rd_phys;
    logic              wr_en;

    // Out-of-range selects match no channel and fall through to zero.
    always_comb begin
        live_mux = '0;
        cap_mux  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_select == SEL_W'(k)) live_mux = i_ch_data[k*DATA_W +: DATA_W];
            if (cap_sel  == SEL_W'(k)) cap_mux  = i_ch_data[k*DATA_W +: DATA_W];
        end
    end

    assign wr_en   = !i_abort && !i_arm && (state == ARMED || state == POST);
    assign rd_phys = wrapped ? (wr_ptr + i_rd_addr) : i_rd_addr;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cap_sel     <= '0;
            wr_ptr      <= '0;
            post_rem    <= '0;
            valid_cnt   <= '0;
            wrapped     <= 1'b0;
            rd_ok       <= 1'b0;
            o_live_data <= '0;
        end else begin
            o_live_data <= live_mux;
            rd_ok       <= 1'b1;
            if (i_abort) begin
                state <= IDLE;
            end else if (i_arm) begin
                state     <= ARMED;
                cap_sel   <= i_select;
                post_rem  <= i_post_cnt;
                wr_ptr    <= '0;
                valid_cnt <= '0;
                wrapped   <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == ADDR_W'(DEPTH - 1)) wrapped <= 1'b1;
                if (valid_cnt != CNT_W'(DEPTH)) valid_cnt <= valid_cnt + CNT_W'(1);
                if (state == ARMED) begin
                    if (i_trig) state <= (post_rem == '0) ? DONE : POST;
                end else begin
                    post_rem <= post_rem - ADDR_W'(1);
                    if (post_rem <= ADDR_W'(1)) state <= DONE;
                end
            end
        end
    end

    // The RAM output register has no reset; gate it so read data is zero until the first edge after reset.
    assign o_rd_data   = rd_ok ? ram_q : '0;
    assign o_state     = state;
    assign o_done      = (state == DONE);
    assign o_valid_cnt = valid_cnt;

    dbg_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (cap_mux),
        .raddr (rd_phys),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_dbg_trace_capture.sv
// Scoreboard bench for dbg_trace_capture with DEPTH=8, NUM_CH=4; ch k carries k<<28 + edge number.
module tb_dbg_trace_capture;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;

    localparam int K_LIVE  = 0;
    localparam int K_RD    = 1;
    localparam int K_STATE = 2;
    localparam int K_VALID = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     i_reset_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0] i_ch_data = '0;
    logic [1:0]               i_select = 2'd0;
    logic                     i_arm = 1'b0;
    logic                     i_abort = 1'b0;
    logic                     i_trig = 1'b0;
    logic [2:0]               i_post_cnt = 3'd0;
    logic [2:0]               i_rd_addr = 3'd0;
    logic [DATA_W-1:0]        o_live_data;
    logic [DATA_W-1:0]        o_rd_data;
    logic [1:0]               o_state;
    logic                     o_done;
    logic [3:0]               o_valid_cnt;

    exp_t q[$];
    int   ec = 0;
    int   cur_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   a = 0;

    dbg_trace_capture #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_ch_data   (i_ch_data),
        .i_select    (i_select),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_trig      (i_trig),
        .i_post_cnt  (i_post_cnt),
        .i_rd_addr   (i_rd_addr),
        .o_live_data (o_live_data),
        .o_rd_data   (o_rd_data),
        .o_state     (o_state),
        .o_done      (o_done),
        .o_valid_cnt (o_valid_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] s(input int k, input int n);
        return (32'(k) << 28) + 32'(n);
    endfunction

    // Next edge is cur_n; probe data for that edge is set here.
    task automatic tick();
        @(negedge clk);
        cur_n = ec + 1;
        for (int k = 0; k < NUM_CH; k++) i_ch_data[k*DATA_W +: DATA_W] = s(k, cur_n);
        i_arm   = 1'b0;
        i_trig  = 1'b0;
        i_abort = 1'b0;
    endtask

    task automatic ex(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = cur_n;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic ex_sv(input int st, input int vc, input string nm);
        ex(K_STATE, 32'(st), {nm, "_state"});
        ex(K_VALID, 32'(vc), {nm, "_valid"});
    endtask

    // Monitor: on each edge (or async reset), compare every expectation that has come due.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk or negedge i_reset_n);
            if (clk === 1'b1) ec++;
            #1;
            while (q.size() > 0 && q[0].due <= ec) begin
                e = q.pop_front();
                case (e.kind)
                    K_LIVE:  act = o_live_data;
                    K_RD:    act = o_rd_data;
                    K_STATE: act = 32'(o_state);
                    K_VALID: act = 32'(o_valid_cnt);
                    default: act = 32'(o_done);
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s @edge %0d: got %h, expected %h", e.name, ec, act, e.val);
                end
            end
        end
    end

    initial begin
        // Reset held across an edge
        tick();
        ex_sv(0, 0, "reset");
        ex(K_LIVE, 32'h0, "reset_live");
        ex(K_RD, 32'h0, "reset_rd");
        ex(K_DONE, 32'h0, "reset_done");
        tick();
        i_reset_n = 1'b1;

        // Live mux
        tick(); i_select = 2'd2; ex(K_LIVE, s(2, cur_n), "live_sel2");
        tick(); i_select = 2'd3; ex(K_LIVE, s(3, cur_n), "live_sel3");
        tick(); i_select = 2'd1; ex(K_LIVE, s(1, cur_n), "live_sel1");
        ex_sv(0, 0, "idle");

        // No wrap: 3 pre, trigger, 2 post on ch1
        tick(); i_arm = 1'b1; i_post_cnt = 3'd2; a = cur_n;
        ex_sv(1, 0, "nw_arm");
        for (int i = 1; i <= 3; i++) begin
            tick(); ex_sv(1, i, "nw_pre");
        end
        tick(); i_trig = 1'b1; ex_sv(2, 4, "nw_trig");
        tick(); ex_sv(2, 5, "nw_post");
        tick(); ex_sv(3, 6, "nw_last"); ex(K_DONE, 32'h1, "nw_done");
        for (int i = 0; i < 6; i++) begin
            tick(); i_rd_addr = 3'(i);
            if (i == 2) i_trig = 1'b1;
            ex(K_RD, s(1, a + 1 + i), "nw_rd");
        end
        ex_sv(3, 6, "nw_hold");

        // Wrap: 12 pre, trigger, 3 post on ch2; write pointer lands on 0
        tick(); i_select = 2'd2; i_arm = 1'b1; i_post_cnt = 3'd3; a = cur_n;
        ex_sv(1, 0, "wr_arm");
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 7 || i == 8 || i == 9 || i == 12) ex(K_VALID, 32'((i < 8) ? i : 8), "wr_sat");
        end
        tick(); i_trig = 1'b1; ex(K_STATE, 32'd2, "wr_trig_state");
        tick(); tick();
        tick(); ex_sv(3, 8, "wr_last");
        tick(); i_rd_addr = 3'd0; ex(K_RD, s(2, a + 9), "wr_rd0");
        tick(); i_rd_addr = 3'd4; ex(K_RD, s(2, a + 13), "wr_rd4_trig");
        tick(); i_rd_addr = 3'd7; ex(K_RD, s(2, a + 16), "wr_rd7");

        // Wrap with non-zero write pointer: 5 pre, trigger, 4 post on ch3
        tick(); i_select = 2'd3; i_arm = 1'b1; i_post_cnt = 3'd4; a = cur_n;
        for (int i = 1; i <= 5; i++) tick();
        tick(); i_trig = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        ex_sv(3, 8, "wo_last");
        tick(); i_rd_addr = 3'd0; ex(K_RD, s(3, a + 3), "wo_rd0");
        tick(); i_rd_addr = 3'd2; ex(K_RD, s(3, a + 5), "wo_rd2");
        tick(); i_rd_addr = 3'd7; ex(K_RD, s(3, a + 10), "wo_rd7");

        // Arm and trigger together from DONE, post_cnt=0, ch0
        tick(); i_select = 2'd0; i_arm = 1'b1; i_trig = 1'b1; i_post_cnt = 3'd0; a = cur_n;
        ex_sv(1, 0, "at_arm"); ex(K_DONE, 32'h0, "at_arm_done");
        tick(); ex_sv(1, 1, "at_pre");
        tick(); i_trig = 1'b1; ex_sv(3, 2, "at_trig"); ex(K_DONE, 32'h1, "at_done");
        tick(); i_rd_addr = 3'd0; ex(K_RD, s(0, a + 1), "at_rd0");
        tick(); i_rd_addr = 3'd1; ex(K_RD, s(0, a + 2), "at_rd1");

        // Rearm in DONE with a different capture channel
        tick(); i_select = 2'd2; i_arm = 1'b1; i_post_cnt = 3'd1; a = cur_n;
        ex_sv(1, 0, "ra_arm");
        tick(); i_select = 2'd1; i_trig = 1'b1; ex_sv(2, 1, "ra_trig");
        tick(); ex_sv(3, 2, "ra_last");
        tick(); i_rd_addr = 3'd0; ex(K_RD, s(2, a + 1), "ra_rd0");
        tick(); i_rd_addr = 3'd1; ex(K_RD, s(2, a + 2), "ra_rd1");

        // Abort in POST on ch3; contents held
        tick(); i_select = 2'd3; i_arm = 1'b1; i_post_cnt = 3'd5; a = cur_n;
        tick();
        tick(); i_trig = 1'b1; ex(K_STATE, 32'd2, "ab_trig_state");
        tick(); ex_sv(2, 3, "ab_post");
        tick(); i_abort = 1'b1; ex_sv(0, 3, "ab_abort"); ex(K_DONE, 32'h0, "ab_done");
        tick(); i_trig = 1'b1; ex_sv(0, 3, "ab_idle_trig");
        for (int i = 0; i < 3; i++) begin
            tick(); i_rd_addr = 3'(i); ex(K_RD, s(3, a + 1 + i), "ab_rd");
        end

        // Async reset between edges while in POST
        tick(); i_select = 2'd1; i_arm = 1'b1; i_post_cnt = 3'd6;
        tick();
        tick(); i_trig = 1'b1; ex(K_STATE, 32'd2, "ar_trig_state");
        tick(); ex(K_STATE, 32'd2, "ar_post_state");
        @(negedge clk);
        #2;
        cur_n = ec;
        ex_sv(0, 0, "ar_now");
        ex(K_LIVE, 32'h0, "ar_now_live");
        ex(K_RD, 32'h0, "ar_now_rd");
        ex(K_DONE, 32'h0, "ar_now_done");
        i_reset_n = 1'b0;
        #2;
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); ex_sv(0, 0, "ar_after");
        end

        tick();
        tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations: got %0d left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_trace_capture.md
# dbg_trace_capture

Parametrised debug observation block for the CPU_DSP core. It carries forward the existing select-to-output debug path, now with a registered live output over NUM_CH probe channels. It adds a triggered circular trace buffer: pre-trigger history and a programmable number of post-trigger samples of one selected channel are captured, then read back oldest-first. It sits beside the core, fed by flattened internal probe buses, and drives the top-level debug output.

## Interface
- DATA_W, 32: width of each probe channel
- NUM_CH, 16: number of probe channels
- DEPTH, 64: trace buffer entries (power of two, ≥4)
- SEL_W, $clog2(NUM_CH): channel select width
- ADDR_W, $clog2(DEPTH): buffer address width

Ports:
- clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_ch_data  in  NUM_CH*DATA_W  probe channels; ch k = bits [k*DATA_W +: DATA_W]
- i_select  in  SEL_W  channel for the live output; latched as capture channel on arm
- i_arm  in  1  one-cycle pulse: start (or restart) a capture
- i_abort  in  1  one-cycle pulse: stop capture, go IDLE
- i_trig  in  1  trigger event (level sampled each cycle)
- i_post_cnt  in  ADDR_W  post-trigger samples after the trigger sample, latched on arm
- i_rd_addr  in  ADDR_W  read index, 0 = oldest valid sample
- o_live_data  out  DATA_W  registered selected channel
- o_rd_data  out  DATA_W  registered buffer read data
- o_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- o_done  out  1  high in DONE
- o_valid_cnt  out  ADDR_W+1  number of valid samples, saturates at DEPTH

## Operation
- Live path: o_live_data <= channel[i_select] every cycle. A select value ≥ NUM_CH gives 0.
- FSM:
  - IDLE: no writes.
  - i_arm (from any state): go to ARMED, latch cap_sel and post_rem = i_post_cnt. wr_ptr and valid_cnt clear to 0, and wrapped clears.
  - ARMED: each cycle write the capture-channel sample at wr_ptr, then wr_ptr++ (mod DEPTH) and valid_cnt++ (saturating).
  - i_trig seen in ARMED: the sample of that cycle is written (the trigger sample). If post_rem==0, go to DONE; otherwise go to POST.
  - POST: write each cycle and decrement post_rem. After the write that takes post_rem to 0, go to DONE.
  - DONE: no writes; contents held until the next arm.
  - i_abort: go to IDLE from any state; buffer contents and pointers are held.
- Priority: i_abort > i_arm > i_trig.
  - Arm and trig in the same cycle: arm is taken and the trigger is ignored; the first sample is written on the following cycle.
  - i_trig in IDLE, POST or DONE: ignored.
- Wrap: when wr_ptr wraps from DEPTH-1 to 0, wrapped is set. Samples older than DEPTH are overwritten.
- Readback: phys = wrapped ? (wr_ptr + i_rd_addr) mod DEPTH : i_rd_addr. An index ≥ o_valid_cnt returns stale or undefined data (not checked).
- Reset: state IDLE, all pointers and counters 0, o_live_data 0, o_rd_data 0, o_valid_cnt 0, o_done 0. The buffer array is not reset.

## Timing
- o_live_data: 1-cycle latency from i_ch_data/i_select.
- o_rd_data: 1-cycle latency from i_rd_addr. It is valid in any state and reflects writes from earlier cycles (the RAM is read-before-write).
- Capture: the sample present on edge N is written at edge N. o_state updates on the same edge.
- The first write happens on the edge after the arm edge.
- Total samples in a capture = pre-trigger samples + 1 + i_post_cnt. DONE is reached on the edge that writes the last sample.
- Reset assertion mid-capture: immediate IDLE, with no further writes.

## Structure
- Package dbg_trace_pkg holds:
  - the state enum (IDLE/ARMED/POST/DONE, 2-bit)
  - the state encoding constants used by o_state
- Sub-module dbg_trace_ram: single-port-write / single-port-read synchronous RAM (DEPTH × DATA_W, registered read), with no reset.
- The top level holds the FSM, pointers, channel mux and address translation.

## Test plan
All scenarios use DEPTH=8, NUM_CH=4, DATA_W=32, with ch k driven to 32'hk000_0000 + cycle count.
- Live mux: select=2 → o_live_data = ch2 one cycle later; select=3 then a swap to 1 follows with one cycle of latency.
- No wrap: arm, trig 3 cycles later, post_cnt=2 → DONE, o_valid_cnt=6. rd_addr 0..5 returns samples 1..6 in order.
- Wrap: arm, trig after 12 cycles, post_cnt=3 → o_valid_cnt=8. rd_addr 0 returns the oldest surviving sample (the trigger sample is at index 4), and rd_addr 7 returns the last post sample.
- post_cnt=0 and arm+trig in the same cycle:
  - With post_cnt=0, a trigger gives DONE on the trigger edge.
  - A simultaneous arm+trig stays ARMED with no writes that cycle.
- Abort and rearm:
  - Abort in POST → IDLE, contents held and readable.
  - Arm in DONE restarts with o_valid_cnt=0 and cap_sel re-latched.
- Async reset mid-POST: i_reset_n low between edges → outputs 0 and IDLE immediately, with no further writes after release until the next arm.
